// File: rtl/can_pkg.sv
// Shared definitions for the CAN transmit scheduler.
//   - can_state_t  : scheduler FSM state encoding
//   - CAN_*        : frame field widths, DLC ceiling, default interframe space
//   - clamp_dlc()  : limits a data length code to the 8-byte maximum
package can_pkg;

    localparam int CAN_ID_W     = 11;
    localparam int CAN_DLC_W    = 4;
    localparam int CAN_DLC_MAX  = 8;
    localparam int CAN_IFS_BITS = 11;
    localparam int CAN_IDX_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_WAIT_IFS = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_LOST     = 3'd4
    } can_state_t;

    function automatic logic [CAN_DLC_W-1:0] clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
        return (dlc > CAN_DLC_W'(CAN_DLC_MAX)) ? CAN_DLC_W'(CAN_DLC_MAX) : dlc;
    endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational priority picker over NUM_MB mailboxes.
//   req   : per-mailbox request
//   ids   : packed 11-bit identifiers, mailbox k at [11k+10:11k]
//   valid : at least one mailbox requesting
//   idx   : requesting mailbox with the lowest identifier; lowest index on ties
module can_prio_select
    import can_pkg::*;
#(
    parameter int NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]          req,
    input  logic [NUM_MB*CAN_ID_W-1:0] ids,
    output logic                       valid,
    output logic [CAN_IDX_W-1:0]       idx
);

    logic [CAN_ID_W-1:0] best_id;

    always_comb begin
        valid   = 1'b0;
        idx     = '0;
        best_id = '0;
        // Strict less-than keeps the earlier (lower) index on equal IDs.
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (req[i] && (!valid || (ids[i*CAN_ID_W +: CAN_ID_W] < best_id))) begin
                valid   = 1'b1;
                idx     = CAN_IDX_W'(i);
                best_id = ids[i*CAN_ID_W +: CAN_ID_W];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN transmit node among NUM_MB mailboxes: picks the pending frame
// with the lowest identifier, waits for IFS_BITS recessive bits, launches it,
// retries on arbitration loss and reports per-mailbox done / fail pulses.
//   can_clk, reset          : bit clock, synchronous active-high reset
//   mb_req/id/dlc/data      : packed per-mailbox requests and frames
//   mb_done, mb_fail        : 1-cycle per-mailbox outcome pulses
//   bus_rx                  : sampled bus level (1 = recessive)
//   tx_start/id/dlc/data    : launch pulse and latched frame to the node
//   tx_done, tx_lost        : node outcome pulses
//   busy, cur_mb            : not-idle flag, latched mailbox index
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int IFS_BITS  = CAN_IFS_BITS,
    parameter int MAX_RETRY = 8,
    parameter int DATA_W    = 64
) (
    input  logic                        can_clk,
    input  logic                        reset,
    input  logic [NUM_MB-1:0]           mb_req,
    input  logic [NUM_MB*CAN_ID_W-1:0]  mb_id,
    input  logic [NUM_MB*CAN_DLC_W-1:0] mb_dlc,
    input  logic [NUM_MB*DATA_W-1:0]    mb_data,
    output logic [NUM_MB-1:0]           mb_done,
    output logic [NUM_MB-1:0]           mb_fail,
    input  logic                        bus_rx,
    output logic                        tx_start,
    output logic [CAN_ID_W-1:0]         tx_id,
    output logic [CAN_DLC_W-1:0]        tx_dlc,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_done,
    input  logic                        tx_lost,
    output logic                        busy,
    output logic [CAN_IDX_W-1:0]        cur_mb
);

    localparam int IFS_W = $clog2(IFS_BITS + 1);

    can_state_t             state_q, state_d;
    logic [IFS_W-1:0]       ifs_cnt_q, ifs_cnt_d;
    logic [3:0]             retry_cnt_q, retry_cnt_d;
    logic                   from_lost_q, from_lost_d;
    logic [CAN_IDX_W-1:0]   cur_mb_q, cur_mb_d;
    logic [CAN_ID_W-1:0]    tx_id_q, tx_id_d;
    logic [CAN_DLC_W-1:0]   tx_dlc_q, tx_dlc_d;
    logic [DATA_W-1:0]      tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic [NUM_MB-1:0]      mb_done_q, mb_done_d;
    logic [NUM_MB-1:0]      mb_fail_q, mb_fail_d;

    logic                   sel_valid;
    logic [CAN_IDX_W-1:0]   sel_idx;
    logic [CAN_ID_W-1:0]    sel_id;
    logic [CAN_DLC_W-1:0]   sel_dlc;
    logic [DATA_W-1:0]      sel_data;
    logic                   cur_req;
    logic [NUM_MB-1:0]      cur_onehot;
    logic                   bus_idle;

    can_prio_select #(.NUM_MB(NUM_MB)) u_prio (
        .req   (mb_req),
        .ids   (mb_id),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    assign bus_idle = (ifs_cnt_q == IFS_W'(IFS_BITS));

    // Frame fields of the winning mailbox, and request / one-hot of the latched one.
    always_comb begin
        sel_id     = '0;
        sel_dlc    = '0;
        sel_data   = '0;
        cur_req    = 1'b0;
        cur_onehot = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (CAN_IDX_W'(i) == sel_idx) begin
                sel_id   = mb_id[i*CAN_ID_W +: CAN_ID_W];
                sel_dlc  = mb_dlc[i*CAN_DLC_W +: CAN_DLC_W];
                sel_data = mb_data[i*DATA_W +: DATA_W];
            end
            if (CAN_IDX_W'(i) == cur_mb_q) begin
                cur_req       = mb_req[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        from_lost_d = from_lost_q;
        cur_mb_d    = cur_mb_q;
        tx_id_d     = tx_id_q;
        tx_dlc_d    = tx_dlc_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        mb_done_d   = '0;
        mb_fail_d   = '0;

        if (!bus_rx)
            ifs_cnt_d = '0;
        else if (!bus_idle)
            ifs_cnt_d = ifs_cnt_q + IFS_W'(1);
        else
            ifs_cnt_d = ifs_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|mb_req)
                    state_d = ST_SELECT;
            end
            ST_SELECT: begin
                from_lost_d = 1'b0;
                if (!sel_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    // A retried frame keeps its count only if it wins re-selection.
                    if (!from_lost_q || (sel_idx != cur_mb_q))
                        retry_cnt_d = '0;
                    cur_mb_d  = sel_idx;
                    tx_id_d   = sel_id;
                    tx_dlc_d  = clamp_dlc(sel_dlc);
                    tx_data_d = sel_data;
                    state_d   = ST_WAIT_IFS;
                end
            end
            ST_WAIT_IFS: begin
                if (!cur_req) begin
                    state_d = ST_IDLE;
                end else if (bus_idle) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (tx_done) begin
                    mb_done_d = cur_onehot;
                    state_d   = ST_IDLE;
                end else if (tx_lost) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                if (({1'b0, retry_cnt_q} + 5'd1) == 5'(MAX_RETRY)) begin
                    mb_fail_d = cur_onehot;
                    state_d   = ST_IDLE;
                end else begin
                    if (retry_cnt_q != 4'hF)
                        retry_cnt_d = retry_cnt_q + 4'd1;
                    from_lost_d = 1'b1;
                    state_d     = ST_SELECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge can_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ifs_cnt_q   <= '0;
            retry_cnt_q <= '0;
            from_lost_q <= 1'b0;
            cur_mb_q    <= '0;
            tx_id_q     <= '0;
            tx_dlc_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            mb_done_q   <= '0;
            mb_fail_q   <= '0;
        end else begin
            state_q     <= state_d;
            ifs_cnt_q   <= ifs_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            from_lost_q <= from_lost_d;
            cur_mb_q    <= cur_mb_d;
            tx_id_q     <= tx_id_d;
            tx_dlc_q    <= tx_dlc_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            mb_done_q   <= mb_done_d;
            mb_fail_q   <= mb_fail_d;
        end
    end

    assign mb_done  = mb_done_q;
    assign mb_fail  = mb_fail_q;
    assign tx_start = tx_start_q;
    assign tx_id    = tx_id_q;
    assign tx_dlc   = tx_dlc_q;
    assign tx_data  = tx_data_q;
    assign cur_mb   = cur_mb_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
